serial_add_ctrl: RTL and testbench

- Bit-serial add/subtract controller that time-multiplexes one 1-bit full-adder cell over WIDTH cycles to produce a WIDTH-bit sum or difference.
- Sequences operand shifting, carry storage and result assembly, and exposes a start/busy/done handshake.
- Sits between a host or test sequencer and the full-adder datapath, trading latency for area.

---
 rtl/serial_add_pkg.sv | 14 +
 rtl/serial_fa_bit.sv | 16 +
 rtl/serial_add_ctrl.sv | 115 +++++++++++
 tb/tb_serial_add_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial add/subtract controller:
// FSM state encodings and the default operand width.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/serial_fa_bit.sv
// One-bit full-adder cell; the only arithmetic in the serial datapath.
module serial_fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Plain full-adder equations
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller. One full-adder cell is reused for
// WIDTH steps, LSB first; the result is assembled in a right-shifting register.
//
// Handshake: start is sampled only while idle (busy=0, done=0). A start seen
// in any other state is dropped, not queued. busy is high in LOAD and RUN;
// done pulses for one cycle, and result/cout/ovf are valid from that cycle
// until the next completion (or reset).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output state_e           dbg_state
);

  state_e           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] r_next;
  logic             last_step;

  serial_fa_bit u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Next result image and final-step detect for the current bit-step
  always_comb begin
    r_next    = {fa_sum, r_sr[WIDTH-1:1]};
    last_step = (cnt == CNT_W'(WIDTH - 1));
  end

  assign dbg_state = state;

  // Controller FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Subtract is A + ~B + 1; the +1 enters through the carry flop.
            a_sr  <= a_in;
            b_sr  <= sub ? ~b_in : b_in;
            carry <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          state <= RUN;
        end
        RUN: begin
          r_sr  <= r_next;
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= fa_cout;
          cnt   <= cnt + 1'b1;
          if (last_step) begin
            // Signed overflow: carry into the MSB differs from carry out of it.
            ovf    <= carry ^ fa_cout;
            cout   <= fa_cout;
            result <= r_next;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8).
module tb_serial_add_ctrl;
  import serial_add_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  state_e       dbg_state;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sub       (sub),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W+1:0] exp_q[$];       // {result, cout, ovf}
  int           n_checks = 0;
  int           n_pass   = 0;
  int           phase    = 0;   // 0 idle, 1 load, 2..W+1 run, W+2 done
  int           n_done   = 0;
  logic [W+1:0] cur_exp  = '0;  // expected outcome of the op in flight
  logic [W+1:0] held     = '0;  // expected value on result/cout/ovf

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference arithmetic from unsigned and signed integer views
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
    logic [W:0] u;
    int         sa;
    int         sbv;
    int         ires;
    logic       v;
    u    = s ? ({1'b0, a} + {1'b0, ~b} + (W+1)'(1)) : ({1'b0, a} + {1'b0, b});
    sa   = int'($signed(a));
    sbv  = int'($signed(b));
    ires = s ? (sa - sbv) : (sa + sbv);
    v    = (ires > 127) || (ires < -128);
    return {u[W-1:0], u[W], v};
  endfunction

  // One clock: drive inputs, advance the timing model, check outputs after the edge
  task automatic step(input logic st, input logic sb, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic r);
    logic [W+1:0] e;
    start = st; sub = sb; a_in = a; b_in = b; rst = r;
    @(posedge clk);
    if (r) begin
      phase = 0;
      exp_q.delete();
      held = '0;
    end else if (phase == 0) begin
      if (st) begin
        phase   = 1;
        cur_exp = ref_op(a, b, sb);
        exp_q.push_back(cur_exp);
      end
    end else if (phase == W + 2) begin
      phase = 0;
    end else begin
      phase++;
      if (phase == W + 2) held = cur_exp;
    end
    #1;
    check("busy", 32'(busy), 32'((phase >= 1) && (phase <= W + 1)));
    check("done", 32'(done), 32'(phase == W + 2));
    check("outputs_held", 32'({result, cout, ovf}), 32'(held));
    if (done) begin
      n_done++;
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_result", 32'({result, cout, ovf}), 32'(e));
      end
    end
  endtask

  // Full operation: accept then idle until the next acceptable IDLE cycle
  task automatic run_op(input logic sb, input logic [W-1:0] a, input logic [W-1:0] b);
    step(1'b1, sb, a, b, 1'b0);
    for (int k = 0; k < W + 2; k++)
      step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           8'($urandom_range(0, 255)), 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    start = 1'b0; sub = 1'b0; a_in = '0; b_in = '0; rst = 1'b1;
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_result", 32'({result, cout, ovf}), 32'd0);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Directed arithmetic cases including carry and overflow corners
    d0 = n_done;
    run_op(1'b0, 8'h05, 8'h03);
    check("add_05_03", 32'({result, cout, ovf}), 32'({8'h08, 1'b0, 1'b0}));
    check("one_done", 32'(n_done - d0), 32'd1);
    run_op(1'b0, 8'hFF, 8'h01);
    check("add_ff_01", 32'({result, cout, ovf}), 32'({8'h00, 1'b1, 1'b0}));
    run_op(1'b0, 8'h7F, 8'h01);
    check("add_7f_01", 32'({result, cout, ovf}), 32'({8'h80, 1'b0, 1'b1}));
    run_op(1'b1, 8'h05, 8'h07);
    check("sub_05_07", 32'({result, cout, ovf}), 32'({8'hFE, 1'b0, 1'b0}));
    run_op(1'b1, 8'h80, 8'h01);
    check("sub_80_01", 32'({result, cout, ovf}), 32'({8'h7F, 1'b1, 1'b1}));

    // Starts during RUN and DONE are dropped; the following IDLE start is taken
    d0 = n_done;
    step(1'b1, 1'b0, 8'h10, 8'h20, 1'b0);
    for (int k = 1; k <= W + 2; k++)
      step((k == 5) || (k == W + 2), 1'b0, 8'hAA, 8'h55, 1'b0);
    check("ignore_one_done", 32'(n_done - d0), 32'd1);
    check("ignore_result", 32'(result), 32'h30);
    run_op(1'b0, 8'hAA, 8'h55);
    check("idle_start", 32'({result, cout, ovf}), 32'({8'hFF, 1'b0, 1'b0}));

    // Reset in the middle of RUN aborts without a done pulse
    run_op(1'b0, 8'h05, 8'h03);
    d0 = n_done;
    step(1'b1, 1'b0, 8'h7F, 8'h01, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_outputs", 32'({result, cout, ovf}), 32'd0);
    for (int k = 0; k < W + 4; k++) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    check("abort_no_done", 32'(n_done - d0), 32'd0);
    run_op(1'b0, 8'h7F, 8'h01);
    check("after_abort", 32'({result, cout, ovf}), 32'({8'h80, 1'b0, 1'b1}));

    // start held high: back-to-back operations every W+3 cycles
    d0 = n_done;
    for (int k = 0; k < 4 * (W + 3); k++)
      step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           8'($urandom_range(0, 255)), 1'b0);
    check("b2b_done_count", 32'(n_done - d0), 32'd4);

    // Random individual operations
    for (int k = 0; k < 20; k++)
      run_op(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
